// File: rtl/guess_evaluator_if.sv
// Handshake/data bundle between the Mastermind code-breaker stage and its surroundings.
// Signal names match the original flat port list so connections map one-to-one.
interface guess_evaluator_if;
  logic        started;
  logic [11:0] secret;
  logic        maker_p;
  logic        enterA;
  logic        enterB;
  logic [2:0]  SW;
  logic        new_game;

  logic        take_guess;
  logic [2:0]  sym_idx;
  logic [2:0]  exact;
  logic [2:0]  partial;
  logic        result_valid;
  logic [3:0]  guess_count;
  logic        win;
  logic        lose;
  logic        game_over;

  modport master (
    output started, secret, maker_p, enterA, enterB, SW, new_game,
    input  take_guess, sym_idx, exact, partial, result_valid, guess_count,
           win, lose, game_over
  );

  modport slave (
    input  started, secret, maker_p, enterA, enterB, SW, new_game,
    output take_guess, sym_idx, exact, partial, result_valid, guess_count,
           win, lose, game_over
  );
endinterface

// File: rtl/guess_evaluator.sv
// Mastermind code-breaker: latches the secret, collects four guess symbols, scores them.
// Define GUESS_EVAL_PARTIAL_EN to build colour-only (partial) scoring; otherwise partial is 0.
module guess_evaluator #(
  parameter int unsigned MAX_GUESSES = 10
) (
  input logic              clk,
  input logic              reset,
  guess_evaluator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, EVAL, SHOW, OVER} state_t;

  localparam logic [3:0] MAX_COUNT = 4'(MAX_GUESSES);

  state_t      state_q, state_d;
  logic [11:0] secret_q, secret_d;
  logic [11:0] guess_q, guess_d;
  logic [2:0]  sym_idx_q, sym_idx_d;
  logic [2:0]  exact_q, exact_d;
  logic [3:0]  guess_count_q, guess_count_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;

  logic        enter_ok;
  logic        abort;
  logic [2:0]  exact_now;
  logic [2:0]  exact_fin;
  logic        score;

`ifdef GUESS_EVAL_PARTIAL_EN
  logic [3:0]  step_q, step_d;
  logic [2:0]  exact_acc_q, exact_acc_d;
  logic [2:0]  match_acc_q, match_acc_d;
  logic [2:0]  partial_q, partial_d;
  logic [2:0]  colour;

  function automatic logic [2:0] count_colour(input logic [11:0] code, input logic [2:0] c);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (code[3*i +: 3] == c) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction
`endif

  function automatic logic [2:0] count_exact(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (a[3*i +: 3] == b[3*i +: 3]) n = n + 3'd1;
    return n;
  endfunction

  assign enter_ok  = bus.maker_p ? bus.enterA : bus.enterB;
  assign abort     = !bus.started && (state_q inside {COLLECT, EVAL, SHOW});
  assign exact_now = count_exact(guess_q, secret_q);

  always_comb begin
    state_d       = state_q;
    secret_d      = secret_q;
    guess_d       = guess_q;
    sym_idx_d     = sym_idx_q;
    exact_d       = exact_q;
    guess_count_d = guess_count_q;
    win_d         = win_q;
    lose_d        = lose_q;
    exact_fin     = exact_now;
    score         = 1'b0;
`ifdef GUESS_EVAL_PARTIAL_EN
    step_d        = step_q;
    exact_acc_d   = exact_acc_q;
    match_acc_d   = match_acc_q;
    partial_d     = partial_q;
    colour        = 3'(step_q - 4'd1);
`endif

    if (abort) begin
      state_d   = IDLE;
      sym_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.started) begin
            secret_d      = bus.secret;
            guess_d       = '0;
            sym_idx_d     = '0;
            exact_d       = '0;
            guess_count_d = '0;
            win_d         = 1'b0;
            lose_d        = 1'b0;
`ifdef GUESS_EVAL_PARTIAL_EN
            partial_d     = '0;
`endif
            state_d       = COLLECT;
          end
        end
        COLLECT: begin
          if (enter_ok) begin
            guess_d = {guess_q[8:0], bus.SW};
            if (sym_idx_q == 3'd3) begin
              sym_idx_d = '0;
              state_d   = EVAL;
`ifdef GUESS_EVAL_PARTIAL_EN
              step_d    = '0;
`endif
            end else begin
              sym_idx_d = sym_idx_q + 3'd1;
            end
          end
        end
        EVAL: begin
`ifdef GUESS_EVAL_PARTIAL_EN
          // Step 0 counts positions; steps 1..8 add per-colour overlaps. The last
          // colour's contribution is folded in combinationally on the SHOW-entry edge.
          if (step_q == 4'd0) begin
            exact_acc_d = exact_now;
            match_acc_d = '0;
          end else begin
            match_acc_d = match_acc_q + min3(count_colour(secret_q, colour),
                                             count_colour(guess_q, colour));
          end
          step_d    = step_q + 4'd1;
          exact_fin = exact_acc_q;
          if (step_q == 4'd8) begin
            score     = 1'b1;
            step_d    = '0;
            partial_d = match_acc_d - exact_acc_q;
          end
`else
          score = 1'b1;
`endif
          if (score) begin
            state_d       = SHOW;
            exact_d       = exact_fin;
            guess_count_d = guess_count_q + 4'd1;
            win_d         = (exact_fin == 3'd4);
            lose_d        = (exact_fin != 3'd4) && ((guess_count_q + 4'd1) == MAX_COUNT);
          end
        end
        SHOW: begin
          state_d = (win_q || lose_q) ? OVER : COLLECT;
        end
        OVER: begin
          if (bus.new_game) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      secret_q      <= '0;
      guess_q       <= '0;
      sym_idx_q     <= '0;
      exact_q       <= '0;
      guess_count_q <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
`ifdef GUESS_EVAL_PARTIAL_EN
      step_q        <= '0;
      exact_acc_q   <= '0;
      match_acc_q   <= '0;
      partial_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      secret_q      <= secret_d;
      guess_q       <= guess_d;
      sym_idx_q     <= sym_idx_d;
      exact_q       <= exact_d;
      guess_count_q <= guess_count_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
`ifdef GUESS_EVAL_PARTIAL_EN
      step_q        <= step_d;
      exact_acc_q   <= exact_acc_d;
      match_acc_q   <= match_acc_d;
      partial_q     <= partial_d;
`endif
    end
  end

  assign bus.take_guess   = (state_q == COLLECT);
  assign bus.result_valid = (state_q == SHOW);
  assign bus.game_over    = (state_q == OVER);
  assign bus.sym_idx      = sym_idx_q;
  assign bus.exact        = exact_q;
  assign bus.guess_count  = guess_count_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
`ifdef GUESS_EVAL_PARTIAL_EN
  assign bus.partial      = partial_q;
`else
  assign bus.partial      = '0;
`endif
endmodule

// File: tb/tb_guess_evaluator.sv
// Bench for guess_evaluator: directed games checked against a per-cycle behavioural
// model plus hand-computed scores. Honours GUESS_EVAL_PARTIAL_EN like the design.
module tb_guess_evaluator;
  localparam int MAXG = 3;
`ifdef GUESS_EVAL_PARTIAL_EN
  localparam int EVAL_CYC = 9;
  localparam bit PART_EN  = 1'b1;
`else
  localparam int EVAL_CYC = 1;
  localparam bit PART_EN  = 1'b0;
`endif

  localparam int P_IDLE = 0, P_COL = 1, P_SCORE = 2, P_SHOW = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 1'b0;

  guess_evaluator_if bus();

  guess_evaluator #(.MAX_GUESSES(MAXG)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: phase, collected symbols, countdown to the scoring edge.
  int          ph = P_IDLE;
  logic [2:0]  m_syms[$];
  int          m_wait = 0;
  logic [11:0] m_secret = '0;
  int          e_exact = 0, e_partial = 0, e_count = 0;
  bit          e_win = 1'b0, e_lose = 1'b0;

  task automatic model_reset();
    ph = P_IDLE; m_syms.delete(); m_wait = 0; m_secret = '0;
    e_exact = 0; e_partial = 0; e_count = 0; e_win = 1'b0; e_lose = 1'b0;
  endtask

  task automatic model_score();
    int ex, mt;
    int cs[8], cg[8];
    ex = 0; mt = 0;
    for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
    for (int i = 0; i < 4; i++) begin
      logic [2:0] s;
      s = m_secret[11-3*i -: 3];
      if (s == m_syms[i]) ex++;
      cs[s]++;
      cg[m_syms[i]]++;
    end
    for (int c = 0; c < 8; c++) mt += (cs[c] < cg[c]) ? cs[c] : cg[c];
    e_exact   = ex;
    e_partial = PART_EN ? (mt - ex) : 0;
    e_count   = e_count + 1;
    e_win     = (ex == 4);
    e_lose    = !e_win && (e_count == MAXG);
  endtask

  task automatic model_step();
    bit ent;
    ent = bus.maker_p ? bus.enterA : bus.enterB;
    if ((ph == P_COL || ph == P_SCORE || ph == P_SHOW) && !bus.started) begin
      ph = P_IDLE;
      m_syms.delete();
    end else begin
      case (ph)
        P_IDLE: if (bus.started) begin
          m_secret = bus.secret; m_syms.delete();
          e_exact = 0; e_partial = 0; e_count = 0; e_win = 1'b0; e_lose = 1'b0;
          ph = P_COL;
        end
        P_COL: if (ent) begin
          m_syms.push_back(bus.SW);
          if (m_syms.size() == 4) begin ph = P_SCORE; m_wait = EVAL_CYC; end
        end
        P_SCORE: begin
          m_wait--;
          if (m_wait == 0) begin model_score(); ph = P_SHOW; end
        end
        P_SHOW: begin
          m_syms.delete();
          ph = (e_win || e_lose) ? P_OVER : P_COL;
        end
        P_OVER: if (bus.new_game) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("take_guess",   int'(bus.take_guess),   int'(ph == P_COL));
        check("result_valid", int'(bus.result_valid), int'(ph == P_SHOW));
        check("game_over",    int'(bus.game_over),    int'(ph == P_OVER));
        check("sym_idx",      int'(bus.sym_idx),      (ph == P_COL) ? m_syms.size() : 0);
        check("exact",        int'(bus.exact),        e_exact);
        check("partial",      int'(bus.partial),      e_partial);
        check("guess_count",  int'(bus.guess_count),  e_count);
        check("win",          int'(bus.win),          int'(e_win));
        check("lose",         int'(bus.lose),         int'(e_lose));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_game(input logic [11:0] s);
    bus.started = 1'b0; bus.new_game = 1'b1; tick();
    bus.new_game = 1'b0; tick();
    bus.secret = s; bus.started = 1'b1; tick();
  endtask

  task automatic enter_sym(input logic [2:0] sym, input bit maker_line);
    bus.SW = sym;
    if (maker_line) bus.enterA = 1'b1; else bus.enterB = 1'b1;
    tick();
    bus.enterA = 1'b0; bus.enterB = 1'b0;
  endtask

  task automatic guess4(input logic [11:0] g, input bit noisy);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] s;
      s = g[11-3*i -: 3];
      if (noisy && i > 0) enter_sym(3'(7 - i), 1'b1);
      enter_sym(s, 1'b0);
    end
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.result_valid && n < 40) begin tick(); n++; end
    if (!bus.result_valid) check("result_timeout", 0, 1);
  endtask

  initial begin
    int  n;
    bit  seen;
    bus.started = 1'b0; bus.secret = '0; bus.maker_p = 1'b0;
    bus.enterA = 1'b0; bus.enterB = 1'b0; bus.SW = '0; bus.new_game = 1'b0;
    tick(2);
    check("rst_take_guess", int'(bus.take_guess), 0);
    check("rst_guess_count", int'(bus.guess_count), 0);
    rst_n = 1'b1;
    tick();

    // Perfect guess 1,2,3,4
    start_game(12'h29C);
    guess4(12'h29C, 1'b0);
    wait_result(n);
    check("perfect_latency", n, EVAL_CYC);
    check("perfect_exact", int'(bus.exact), 4);
    check("perfect_partial", int'(bus.partial), 0);
    check("perfect_count", int'(bus.guess_count), 1);
    check("perfect_win", int'(bus.win), 1);
    tick();
    check("perfect_over", int'(bus.game_over), 1);

    // All colours, no positions
    start_game(12'h29C);
    guess4(12'h8D1, 1'b0);
    wait_result(n);
    check("perm_exact", int'(bus.exact), 0);
    check("perm_partial", int'(bus.partial), PART_EN ? 4 : 0);
    check("perm_win", int'(bus.win), 0);
    tick();
    check("perm_take_guess", int'(bus.take_guess), 1);

    // Duplicate colours, then same guess with maker-line noise
    start_game(12'h252);
    guess4(12'h28B, 1'b0);
    wait_result(n);
    check("dup_exact", int'(bus.exact), 1);
    check("dup_partial", int'(bus.partial), PART_EN ? 2 : 0);
    tick();
    guess4(12'h28B, 1'b1);
    wait_result(n);
    check("noisy_exact", int'(bus.exact), 1);
    check("noisy_partial", int'(bus.partial), PART_EN ? 2 : 0);
    check("noisy_count", int'(bus.guess_count), 2);
    tick();

    // Loss after MAXG wrong guesses
    start_game(12'h29C);
    for (int g = 0; g < 3; g++) begin
      guess4(12'h000, 1'b0);
      wait_result(n);
      tick();
    end
    check("loss_lose", int'(bus.lose), 1);
    check("loss_count", int'(bus.guess_count), 3);
    check("loss_over", int'(bus.game_over), 1);
    enter_sym(3'd5, 1'b0);
    check("over_ignores_enter", int'(bus.sym_idx), 0);
    bus.started = 1'b0; bus.new_game = 1'b1; tick();
    bus.new_game = 1'b0;
    check("newgame_idle", int'(bus.game_over), 0);
    check("newgame_keeps_lose", int'(bus.lose), 1);

    // Abort during scoring
    start_game(12'h29C);
    guess4(12'h000, 1'b0);
    wait_result(n);
    tick();
    guess4(12'h29C, 1'b0);
    bus.started = 1'b0;
    tick();
    check("abort_take_guess", int'(bus.take_guess), 0);
    check("abort_count", int'(bus.guess_count), 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.result_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_result", int'(seen), 0);

    // Asynchronous reset mid-collect, then fresh game with a new secret
    start_game(12'h252);
    enter_sym(3'd1, 1'b0);
    enter_sym(3'd2, 1'b0);
    check("mid_sym_idx", int'(bus.sym_idx), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_sym_idx", int'(bus.sym_idx), 0);
    check("async_take_guess", int'(bus.take_guess), 0);
    check("async_count", int'(bus.guess_count), 0);
    tick();
    bus.secret = 12'h8D1; rst_n = 1'b1;
    tick();
    guess4(12'h8D1, 1'b0);
    wait_result(n);
    check("relatch_exact", int'(bus.exact), 4);
    check("relatch_win", int'(bus.win), 1);
    check("relatch_count", int'(bus.guess_count), 1);
    tick(2);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
